// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: byte/half/word loads and stores on a word-organised
// data memory, MEM/WB pipeline register and a registered debug read port.
module mem_access_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_aluresult,
  input  logic [DATA_WIDTH-1:0] i_regB,
  input  logic [4:0]            i_rd_rt,
  input  logic [2:0]            i_mem,
  input  logic [1:0]            i_wb,
  input  logic [1:0]            i_sizemem,
  input  logic                  i_signedmem,
  input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
  output logic [DATA_WIDTH-1:0] o_readdata,
  output logic [DATA_WIDTH-1:0] o_aluresult,
  output logic [4:0]            o_rd_rt,
  output logic [1:0]            o_wb,
  output logic                  o_misaligned,
  output logic [DATA_WIDTH-1:0] o_dbg_data
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [Depth];

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            lane;
  logic                  memwrite;
  logic                  memread;
  logic                  misaligned;
  logic                  mem_we;
  logic [3:0]            byte_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [DATA_WIDTH-1:0] load_data;

  logic [DATA_WIDTH-1:0] readdata_d, readdata_q;
  logic [DATA_WIDTH-1:0] aluresult_d, aluresult_q;
  logic [4:0]            rd_rt_d, rd_rt_q;
  logic [1:0]            wb_d, wb_q;
  logic                  misaligned_d, misaligned_q;
  logic [DATA_WIDTH-1:0] dbg_data_d, dbg_data_q;

  // Upper address bits wrap away; the branch control bit is consumed elsewhere.
  logic unused_bits;
  assign unused_bits = ^{i_aluresult[DATA_WIDTH-1:ADDR_WIDTH+2], i_mem[2]};

  assign word_idx = i_aluresult[ADDR_WIDTH+1:2];
  assign lane     = i_aluresult[1:0];
  assign memwrite = i_mem[0];
  assign memread  = i_mem[1];

  always_comb begin
    misaligned = 1'b0;
    byte_en    = 4'b0000;
    wdata      = i_regB;
    unique case (i_sizemem)
      2'b00: begin
        byte_en = 4'b0001 << lane;
        wdata   = {(DATA_WIDTH / 8){i_regB[7:0]}};
      end
      2'b01: begin
        misaligned = lane[0];
        byte_en    = lane[1] ? 4'b1100 : 4'b0011;
        wdata      = {(DATA_WIDTH / 16){i_regB[15:0]}};
      end
      default: begin
        misaligned = (lane != 2'b00);
        byte_en    = 4'b1111;
      end
    endcase
    misaligned = misaligned & (memread | memwrite);
    mem_we     = memwrite & ~misaligned;
  end

  // Combinational read of the pre-write word gives read-before-write on a combined access.
  always_comb begin
    rd_word = mem[word_idx];
    rd_byte = rd_word[{lane, 3'b000} +: 8];
    rd_half = rd_word[{lane[1], 4'b0000} +: 16];
    unique case (i_sizemem)
      2'b00:   load_data = {{(DATA_WIDTH - 8){i_signedmem & rd_byte[7]}}, rd_byte};
      2'b01:   load_data = {{(DATA_WIDTH - 16){i_signedmem & rd_half[15]}}, rd_half};
      default: load_data = rd_word;
    endcase
  end

  always_comb begin
    readdata_d   = (memread && !misaligned) ? load_data : '0;
    aluresult_d  = i_aluresult;
    rd_rt_d      = i_rd_rt;
    wb_d         = i_wb;
    misaligned_d = misaligned;
    dbg_data_d   = mem[i_dbg_addr];
  end

  // Memory has no reset; a reset-coincident edge simply suppresses the write.
  always_ff @(posedge i_clock) begin
    if (!i_reset && mem_we) begin
      for (int l = 0; l < 4; l++) begin
        if (byte_en[l]) begin
          mem[word_idx][l*8 +: 8] <= wdata[l*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      readdata_q   <= '0;
      aluresult_q  <= '0;
      rd_rt_q      <= '0;
      wb_q         <= '0;
      misaligned_q <= 1'b0;
      dbg_data_q   <= '0;
    end else begin
      readdata_q   <= readdata_d;
      aluresult_q  <= aluresult_d;
      rd_rt_q      <= rd_rt_d;
      wb_q         <= wb_d;
      misaligned_q <= misaligned_d;
      dbg_data_q   <= dbg_data_d;
    end
  end

  assign o_readdata   = readdata_q;
  assign o_aluresult  = aluresult_q;
  assign o_rd_rt      = rd_rt_q;
  assign o_wb         = wb_q;
  assign o_misaligned = misaligned_q;
  assign o_dbg_data   = dbg_data_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed steps plus random traffic against a
// byte-addressed reference memory.
module tb_mem_access_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int MemBytes = 4 * (2 ** AW);

  logic          i_clock = 1'b0;
  logic          i_reset;
  logic [DW-1:0] i_aluresult;
  logic [DW-1:0] i_regB;
  logic [4:0]    i_rd_rt;
  logic [2:0]    i_mem;
  logic [1:0]    i_wb;
  logic [1:0]    i_sizemem;
  logic          i_signedmem;
  logic [AW-1:0] i_dbg_addr;
  logic [DW-1:0] o_readdata;
  logic [DW-1:0] o_aluresult;
  logic [4:0]    o_rd_rt;
  logic [1:0]    o_wb;
  logic          o_misaligned;
  logic [DW-1:0] o_dbg_data;

  mem_access_stage #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_aluresult (i_aluresult),
    .i_regB      (i_regB),
    .i_rd_rt     (i_rd_rt),
    .i_mem       (i_mem),
    .i_wb        (i_wb),
    .i_sizemem   (i_sizemem),
    .i_signedmem (i_signedmem),
    .i_dbg_addr  (i_dbg_addr),
    .o_readdata  (o_readdata),
    .o_aluresult (o_aluresult),
    .o_rd_rt     (o_rd_rt),
    .o_wb        (o_wb),
    .o_misaligned(o_misaligned),
    .o_dbg_data  (o_dbg_data)
  );

  always #5 i_clock = ~i_clock;

  logic [7:0] mb [MemBytes];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_bytes(input int a, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(mb[(a + i) % MemBytes]) << (8 * i));
    return v;
  endfunction

  // One clock of traffic: predict from the byte model, apply, then compare after the edge.
  task automatic cycle(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] mem,
                       input logic [1:0] size, input logic sgn, input logic [7:0] dbg,
                       input logic [4:0] rr, input logic [1:0] wb, input bit chk_dbg);
    int n;
    int a;
    bit mis;
    logic [31:0] e_rd;
    logic [31:0] e_dbg;
    i_aluresult = addr;
    i_regB      = data;
    i_mem       = mem;
    i_sizemem   = size;
    i_signedmem = sgn;
    i_dbg_addr  = dbg;
    i_rd_rt     = rr;
    i_wb        = wb;
    n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    a   = int'(addr % MemBytes);
    mis = (mem[0] || mem[1]) && (a % n != 0);
    e_rd = '0;
    if (mem[1] && !mis) begin
      e_rd = rd_bytes(a, n);
      if (n < 4 && sgn && e_rd[8*n-1]) e_rd = e_rd - (32'd1 << (8 * n));
    end
    e_dbg = rd_bytes(int'(dbg) * 4, 4);
    if (mem[0] && !mis) begin
      for (int i = 0; i < n; i++) mb[(a + i) % MemBytes] = data[8*i +: 8];
    end
    @(posedge i_clock);
    #1;
    chk("readdata", o_readdata, e_rd);
    chk("aluresult", o_aluresult, addr);
    chk("rd_rt", 32'(o_rd_rt), 32'(rr));
    chk("wb", 32'(o_wb), 32'(wb));
    chk("misaligned", 32'(o_misaligned), 32'(mis));
    if (chk_dbg) chk("dbg_data", o_dbg_data, e_dbg);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_readdata"}, o_readdata, 32'd0);
    chk({tag, "_aluresult"}, o_aluresult, 32'd0);
    chk({tag, "_rd_rt"}, 32'(o_rd_rt), 32'd0);
    chk({tag, "_wb"}, 32'(o_wb), 32'd0);
    chk({tag, "_misaligned"}, 32'(o_misaligned), 32'd0);
    chk({tag, "_dbg"}, o_dbg_data, 32'd0);
  endtask

  task automatic rand_inputs();
    i_aluresult = $urandom;
    i_regB      = $urandom;
    i_rd_rt     = 5'($urandom);
    i_mem       = 3'($urandom);
    i_wb        = 2'($urandom);
    i_sizemem   = 2'($urandom);
    i_signedmem = 1'($urandom);
    i_dbg_addr  = 8'($urandom);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] addr;
    // Asynchronous reset before any clock edge, then held across an edge with a store presented.
    i_reset = 1'b0;
    rand_inputs();
    #1 i_reset = 1'b1;
    #1 chk_all_zero("rst_async");
    i_mem = 3'b001;
    @(posedge i_clock);
    #1 chk_all_zero("rst_edge");
    @(negedge i_clock);
    i_reset = 1'b0;
    #1 chk_all_zero("rst_release");

    // Fill memory so every later read is defined.
    for (int w = 0; w < 2 ** AW; w++) begin
      cycle(32'(w * 4), $urandom, 3'b001, 2'd2, 1'b0, (w == 0) ? 8'd0 : 8'(w - 1),
            5'($urandom), 2'($urandom), w != 0);
    end

    // Word store/load.
    cycle(32'h10, 32'hDEADBEEF, 3'b001, 2'd2, 1'b0, 8'd4, 5'($urandom), 2'($urandom), 1);
    cycle(32'h10, 32'h0, 3'b010, 2'd2, 1'b0, 8'd4, 5'($urandom), 2'($urandom), 1);
    chk("lw_10", o_readdata, 32'hDEADBEEF);
    chk("lw_10_mis", 32'(o_misaligned), 32'd0);
    chk("dbg_10", o_dbg_data, 32'hDEADBEEF);

    // Byte store and signed/unsigned byte loads.
    cycle(32'h11, 32'h80, 3'b001, 2'd0, 1'b0, 8'd0, 5'($urandom), 2'($urandom), 1);
    cycle(32'h11, 32'h0, 3'b010, 2'd0, 1'b1, 8'd0, 5'($urandom), 2'($urandom), 1);
    chk("lb_11", o_readdata, 32'hFFFFFF80);
    cycle(32'h11, 32'h0, 3'b010, 2'd0, 1'b0, 8'd0, 5'($urandom), 2'($urandom), 1);
    chk("lbu_11", o_readdata, 32'h00000080);
    cycle(32'h10, 32'h0, 3'b010, 2'd2, 1'b1, 8'd0, 5'($urandom), 2'($urandom), 1);
    chk("lw_10_b", o_readdata, 32'hDEAD80EF);

    // Halfword store and loads.
    cycle(32'h20, 32'h0, 3'b001, 2'd2, 1'b0, 8'd8, 5'($urandom), 2'($urandom), 1);
    cycle(32'h22, 32'h8001, 3'b001, 2'd1, 1'b0, 8'd8, 5'($urandom), 2'($urandom), 1);
    cycle(32'h22, 32'h0, 3'b010, 2'd1, 1'b1, 8'd8, 5'($urandom), 2'($urandom), 1);
    chk("lh_22", o_readdata, 32'hFFFF8001);
    cycle(32'h22, 32'h0, 3'b010, 2'd1, 1'b0, 8'd8, 5'($urandom), 2'($urandom), 1);
    chk("lhu_22", o_readdata, 32'h00008001);
    cycle(32'h20, 32'h0, 3'b010, 2'd2, 1'b0, 8'd8, 5'($urandom), 2'($urandom), 1);
    chk("lw_20", o_readdata, 32'h80010000);

    // Misaligned accesses: no data, flag set, memory unchanged.
    cycle(32'h13, 32'h0, 3'b010, 2'd2, 1'b0, 8'd8, 5'($urandom), 2'($urandom), 1);
    chk("lw_13_mis", 32'(o_misaligned), 32'd1);
    chk("lw_13_data", o_readdata, 32'd0);
    cycle(32'h21, 32'hFFFF, 3'b001, 2'd1, 1'b0, 8'd8, 5'($urandom), 2'($urandom), 1);
    chk("sh_21_mis", 32'(o_misaligned), 32'd1);
    cycle(32'h0, 32'h0, 3'b000, 2'd1, 1'b0, 8'd8, 5'($urandom), 2'($urandom), 1);
    chk("sh_21_mem", o_dbg_data, 32'h80010000);

    // Address wrap and pass-through.
    cycle(32'h400, 32'h12345678, 3'b001, 2'd2, 1'b0, 8'd0, 5'd17, 2'b10, 1);
    chk("pass_rd_rt", 32'(o_rd_rt), 32'd17);
    chk("pass_wb", 32'(o_wb), 32'd2);
    cycle(32'h0, 32'h0, 3'b010, 2'd2, 1'b0, 8'd0, 5'($urandom), 2'($urandom), 1);
    chk("wrap_lw_0", o_readdata, 32'h12345678);

    // Reset during a store: no write, outputs held at zero until the first edge after release.
    @(negedge i_clock);
    i_reset = 1'b1;
    rand_inputs();
    i_aluresult = 32'h40;
    i_mem       = 3'b001;
    i_sizemem   = 2'd2;
    #1 chk_all_zero("rst_mid");
    @(posedge i_clock);
    #1 chk_all_zero("rst_mid_edge");
    @(negedge i_clock);
    i_reset = 1'b0;
    i_mem   = 3'b000;
    #1 chk("rst_hold_wb", 32'(o_wb), 32'd0);
    @(posedge i_clock);
    #1;
    cycle(32'h0, 32'h0, 3'b000, 2'd2, 1'b0, 8'h10, 5'($urandom), 2'($urandom), 1);

    // Random traffic concentrated on a small window to provoke store/load collisions.
    for (int k = 0; k < 400; k++) begin
      addr = $urandom_range(0, 255);
      if ($urandom_range(0, 7) == 0) addr = addr | ($urandom & 32'hFFFF_FC00);
      d = $urandom;
      cycle(addr, d, 3'($urandom), 2'($urandom), 1'($urandom), 8'($urandom_range(0, 63)),
            5'($urandom), 2'($urandom), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
